// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave receiver that assembles oversampled bytes into multi-byte frames.
// Define SPI_SLAVE_ECHO_EN to shift the previous rx_byte back out on MISO; otherwise MISO is tied low.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int FRAME_BYTES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          SCLK,
  input  logic                          MOSI,
  input  logic                          SS_n,
  output logic                          MISO,
  output logic [DATA_W-1:0]             rx_byte,
  output logic                          rx_byte_valid,
  output logic [DATA_W*FRAME_BYTES-1:0] frame_data,
  output logic                          frame_valid,
  output logic                          frame_err
);
  localparam int BW = $clog2(DATA_W);
  localparam int CW = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, BYTE, ABORT} state_t;
  state_t                                 state_q;
  logic [SYNC_STAGES-1:0]                 sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                                   sclk_prev_q;
  logic [DATA_W-1:0]                      shift_q, rx_byte_q;
  logic [BW-1:0]                          bit_cnt_q;
  logic [CW-1:0]                          byte_cnt_q;
  logic [FRAME_BYTES-1:0][DATA_W-1:0]     frame_reg_q, frame_d, frame_out_q;
  logic                                   rx_byte_valid_q, frame_valid_q, frame_err_q;
  logic                                   sclk_s, mosi_s, ss_s, sclk_rise;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  // first byte of a frame lands in the most significant slot
  always_comb begin
    frame_d = frame_reg_q;
    frame_d[CW'(FRAME_BYTES-1) - byte_cnt_q] = shift_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      sclk_sync_q     <= '0;
      mosi_sync_q     <= '0;
      ss_sync_q       <= '1;
      sclk_prev_q     <= 1'b0;
      shift_q         <= '0;
      rx_byte_q       <= '0;
      bit_cnt_q       <= '0;
      byte_cnt_q      <= '0;
      frame_reg_q     <= '0;
      frame_out_q     <= '0;
      rx_byte_valid_q <= 1'b0;
      frame_valid_q   <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      sclk_sync_q     <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q     <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_sync_q       <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      sclk_prev_q     <= sclk_s;
      rx_byte_valid_q <= 1'b0;
      frame_valid_q   <= 1'b0;
      frame_err_q     <= 1'b0;
      case (state_q)
        IDLE: if (!ss_s) begin
          state_q    <= SHIFT;
          bit_cnt_q  <= '0;
          byte_cnt_q <= '0;
        end
        SHIFT: if (ss_s) state_q <= ABORT;
        else if (sclk_rise) begin
          shift_q   <= {shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_q <= bit_cnt_q == BW'(DATA_W-1) ? '0 : bit_cnt_q + 1'b1;
          state_q   <= bit_cnt_q == BW'(DATA_W-1) ? BYTE : SHIFT;
        end
        BYTE: begin
          rx_byte_q       <= shift_q;
          rx_byte_valid_q <= 1'b1;
          frame_reg_q     <= frame_d;
          state_q         <= SHIFT;
          if (byte_cnt_q == CW'(FRAME_BYTES-1)) begin
            frame_out_q   <= frame_d;
            frame_valid_q <= 1'b1;
            byte_cnt_q    <= '0;
          end else byte_cnt_q <= byte_cnt_q + 1'b1;
        end
        ABORT: begin
          frame_err_q <= bit_cnt_q != '0 || byte_cnt_q != '0;
          shift_q     <= '0;
          bit_cnt_q   <= '0;
          byte_cnt_q  <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign frame_data    = frame_out_q;
  assign frame_valid   = frame_valid_q;
  assign frame_err     = frame_err_q;
`ifdef SPI_SLAVE_ECHO_EN
  logic [DATA_W-1:0] echo_q;
  logic              sclk_fall;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // a falling edge with bit_cnt at 0 closes a byte, so the next echo byte is reloaded there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) echo_q <= '0;
    else if (state_q == IDLE) echo_q <= ss_s ? '0 : rx_byte_q;
    else if (state_q == ABORT) echo_q <= '0;
    else if (state_q == SHIFT && !ss_s && sclk_fall)
      echo_q <= bit_cnt_q == '0 ? rx_byte_q : {echo_q[DATA_W-2:0], 1'b0};
  end
  assign MISO = echo_q[DATA_W-1];
`else
  assign MISO = 1'b0;
`endif
endmodule
